// File: rtl/sixteen_bit_down_timer.sv
// sixteen_bit_down_timer
//
// Programmable down-counting timer. It accepts a cycle count, counts it down
// to zero once started, and flags expiry with a one-cycle pulse. It shares a
// clock domain with the free-running up-counter.
//
// Optional build macro: DOWN_TIMER_AUTO_RELOAD_EN
//   Defined:   the terminal edge in RUN reloads the last accepted value and
//              the timer keeps running, which gives a periodic tick. A zero
//              reload value still finishes in DONE.
//   Undefined: single-shot operation.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   load_valid  in   load request
//   load_ready  out  load can be accepted (every state except RUN)
//   load_value  in   cycles to count, WIDTH bits
//   start       in   begin counting the loaded value (ARMED only)
//   pause       in   hold the count while in RUN
//   abort       in   cancel and return to IDLE; highest priority
//   count       out  remaining count (registered), WIDTH bits
//   busy        out  high while in RUN
//   expired     out  one-cycle pulse on terminal count (registered)
//   done        out  level, high in DONE until the next load or abort
module sixteen_bit_down_timer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             expired,
   output logic             done
);

   typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             expired_q, expired_d;
   logic             done_q, done_d;
   logic             load_acc;

   assign load_ready = (state_q != StRun);
   assign load_acc   = load_valid && load_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         count_q   <= '0;
         reload_q  <= '0;
         expired_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         expired_q <= expired_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      expired_d = 1'b0;
      done_d    = done_q;

      if (abort) begin
         // Abort keeps reload so a later auto-reload run is unaffected.
         state_d = StIdle;
         count_d = '0;
         done_d  = 1'b0;
      end else if (load_acc) begin
         // A load beats a simultaneous start; the start is dropped.
         count_d  = load_value;
         reload_d = load_value;
         state_d  = StArmed;
         done_d   = 1'b0;
      end else begin
         unique case (state_q)
            StArmed: begin
               if (start) begin
                  if (count_q == '0) begin
                     state_d   = StDone;
                     expired_d = 1'b1;
                     done_d    = 1'b1;
                  end else begin
                     state_d = StRun;
                  end
               end
            end
            StRun: begin
               if (!pause) begin
                  // The terminal check is at 1, so the count never wraps.
                  if (count_q == WIDTH'(1)) begin
                     expired_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                     if (reload_q != '0) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = StDone;
                        done_d  = 1'b1;
                     end
`else
                     count_d = '0;
                     state_d = StDone;
                     done_d  = 1'b1;
`endif
                  end else begin
                     count_d = count_q - WIDTH'(1);
                  end
               end
            end
            StIdle, StDone: ;
            default: ;
         endcase
      end
   end

`ifndef DOWN_TIMER_AUTO_RELOAD_EN
   // The single-shot build never reads the reload register.
   logic unused_reload;
   assign unused_reload = ^reload_q;
`endif

   assign count   = count_q;
   assign busy    = (state_q == StRun);
   assign expired = expired_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sixteen_bit_down_timer.sv
module tb_sixteen_bit_down_timer;

   localparam int unsigned WIDTH = 16;

   logic             clk;
   logic             reset;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             expired;
   logic             done;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   sixteen_bit_down_timer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .start      (start),
      .pause      (pause),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .expired    (expired),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Compare every output against one expected snapshot.
   task automatic expect_all(input string tag, input int unsigned cnt, input bit exp_expired,
                             input bit exp_done, input bit exp_busy, input bit exp_ready);
      check({tag, ".count"}, 32'(count), 32'(cnt));
      check({tag, ".expired"}, 32'(expired), 32'(exp_expired));
      check({tag, ".done"}, 32'(done), 32'(exp_done));
      check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
      check({tag, ".load_ready"}, 32'(load_ready), 32'(exp_ready));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int unsigned v);
      load_valid = 1'b1;
      load_value = WIDTH'(v);
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      load_valid = 1'b0;
      load_value = '0;
      start      = 1'b0;
      pause      = 1'b0;
      abort      = 1'b0;

      #1 reset = 1'b1;
      #1 expect_all("reset", 0, 0, 0, 0, 1);
      tick();
      reset = 1'b0;
      tick();
      expect_all("idle", 0, 0, 0, 0, 1);

`ifndef DOWN_TIMER_AUTO_RELOAD_EN
      // Load 5 and count down to expiry.
      do_load(5);
      expect_all("l5.armed", 5, 0, 0, 0, 1);
      do_start();
      expect_all("l5.k", 5, 0, 0, 1, 0);
      for (int j = 1; j <= 4; j++) begin
         tick();
         expect_all($sformatf("l5.k+%0d", j), 5 - j, 0, 0, 1, 0);
      end
      tick();
      expect_all("l5.k+5", 0, 1, 1, 0, 1);
      tick();
      expect_all("l5.k+6", 0, 0, 1, 0, 1);
      do_start();
      expect_all("l5.start_in_done", 0, 0, 1, 0, 1);

      // Pause for three cycles after the first decrement.
      do_load(4);
      expect_all("p.armed", 4, 0, 0, 0, 1);
      do_start();
      tick();
      expect_all("p.k+1", 3, 0, 0, 1, 0);
      pause = 1'b1;
      for (int j = 2; j <= 4; j++) begin
         tick();
         expect_all($sformatf("p.k+%0d", j), 3, 0, 0, 1, 0);
      end
      pause = 1'b0;
      tick();
      expect_all("p.k+5", 2, 0, 0, 1, 0);
      tick();
      expect_all("p.k+6", 1, 0, 0, 1, 0);
      tick();
      expect_all("p.k+7", 0, 1, 1, 0, 1);

      // A pause on the count==1 edge blocks that expiry.
      do_load(2);
      do_start();
      tick();
      expect_all("p1.cnt1", 1, 0, 0, 1, 0);
      pause = 1'b1;
      tick();
      expect_all("p1.held", 1, 0, 0, 1, 0);
      pause = 1'b0;
      tick();
      expect_all("p1.exp", 0, 1, 1, 0, 1);
`endif

      // Abort with count 6 together with a load request.
      do_load(10);
      do_start();
      expect_all("ab.k", 10, 0, 0, 1, 0);
      repeat (4) tick();
      expect_all("ab.k+4", 6, 0, 0, 1, 0);
      abort      = 1'b1;
      load_valid = 1'b1;
      load_value = WIDTH'(7);
      tick();
      abort      = 1'b0;
      load_valid = 1'b0;
      expect_all("ab.idle", 0, 0, 0, 0, 1);
      do_start();
      expect_all("ab.start_in_idle", 0, 0, 0, 0, 1);

      // Load and start together in ARMED: the load wins.
      do_load(8);
      load_valid = 1'b1;
      load_value = WIDTH'(3);
      start      = 1'b1;
      tick();
      load_valid = 1'b0;
      start      = 1'b0;
      expect_all("arm.both", 3, 0, 0, 0, 1);
      do_start();
      expect_all("arm.k", 3, 0, 0, 1, 0);
      tick();
      expect_all("arm.k+1", 2, 0, 0, 1, 0);
      tick();
      expect_all("arm.k+2", 1, 0, 0, 1, 0);
      tick();
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      expect_all("arm.k+3", 3, 1, 0, 1, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      expect_all("arm.abort", 0, 0, 0, 0, 1);
`else
      expect_all("arm.k+3", 0, 1, 1, 0, 1);
`endif

      // Zero load: start goes straight to DONE with an expiry pulse.
      do_load(0);
      expect_all("z.armed", 0, 0, 0, 0, 1);
      do_start();
      expect_all("z.start", 0, 1, 1, 0, 1);
      tick();
      expect_all("z.after", 0, 0, 1, 0, 1);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      // Periodic ticks: 3,2,1,3,2,1,...
      do_load(3);
      do_start();
      expect_all("ar.k", 3, 0, 0, 1, 0);
      for (int r = 0; r < 3; r++) begin
         tick();
         expect_all($sformatf("ar.r%0d.2", r), 2, 0, 0, 1, 0);
         tick();
         expect_all($sformatf("ar.r%0d.1", r), 1, 0, 0, 1, 0);
         tick();
         expect_all($sformatf("ar.r%0d.3", r), 3, 1, 0, 1, 0);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
`endif

      // Asynchronous reset between edges while running.
      do_load(9);
      do_start();
      tick();
      expect_all("rst.pre", 8, 0, 0, 1, 0);
      #3 reset = 1'b1;
      #1 expect_all("rst.async", 0, 0, 0, 0, 1);
      reset = 1'b0;
      tick();
      expect_all("rst.after", 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
